moore_seq_detector_param: RTL and testbench
===========================================

// Module: moore_seq_detector_param
// PURPOSE
//   Parametrised Moore serial-pattern detector; successor to the fixed 10010 detector.
//   Samples a 1-bit serial stream j, tracks the longest matched prefix of PATTERN and asserts found
//   for one cycle when the full pattern has been seen. Overlap mode is selectable and a saturating
//   match counter is built in. Sits between serial input conditioning and the control/status logic.
// PARAMETERS
//   PAT_LEN   5          pattern length in bits, 2..16
//   PATTERN   5'b10010   pattern; MSB is received first
//   OVERLAP   1          1: a match may reuse its own suffix; 0: restart from empty after a match
//   CNT_W     8          width of the match counter
// PORTS
//   clk      input   1       rising-edge clock
//   rst      input   1       asynchronous, active-high reset
//   en       input   1       sample enable; j is consumed only on edges where en=1
//   j        input   1       serial data bit
//   clr_cnt  input   1       synchronous counter clear
//   found    output  1       Moore match flag (decoded from state only)
//   state    output  SW      current matched-prefix length 0..PAT_LEN; SW=clog2(PAT_LEN+1)
//   count    output  CNT_W   number of matches, saturating
//   sat      output  1       count has reached 2^CNT_W-1
// BEHAVIOUR
//   - Reset (async, rst=1): state=0, found=0, count=0, sat=0; these hold while rst=1.
//     Any partial match is lost when reset is applied mid-stream.
//   - States S0..S(PAT_LEN): Sk means the last k sampled bits equal PATTERN[PAT_LEN-1 -: k].
//   - Transition on an edge with en=1 from Sk, k<PAT_LEN: if j==PATTERN[PAT_LEN-1-k], go to S(k+1);
//     otherwise go to the longest Sm whose prefix is a suffix of (prefix_k, j). This is KMP fallback,
//     and S0 is allowed.
//   - From S(PAT_LEN): if OVERLAP=1, apply the fallback from the longest proper border length of
//     PATTERN. If OVERLAP=0, take the transition S0 would take on j.
//   - With en=0, state, found, count and sat all hold.
//   - found = (state==PAT_LEN). It is high in the cycle after the edge that samples the final
//     pattern bit, and stays high while en=0.
//   - count increments on the same edge on which state enters S(PAT_LEN), so count and found update
//     together. The latency from the final bit to found is 1 edge.
//   - count saturates at 2^CNT_W-1, where sat=1; further matches leave count unchanged.
//   - clr_cnt=1: count<=0 and sat<=0 on that edge. clr_cnt has priority over a simultaneous match
//     increment. State is not affected by clr_cnt.
//   - The transition table is computed at elaboration by a constant function. There is no runtime
//     pattern load.
//   - Illegal state encodings (> PAT_LEN) recover to S0 on the next enabled edge.
// STRUCTURE
//   - Shared package/header seq_det_pkg:
//     - clog2 constant function;
//     - border/next-state constant function next_state(pattern, len, k, bit, overlap);
//     - state-width macro.
//   - Sub-module seq_det_match_counter (CNT_W): saturating counter with inc, clr and sat.
//   - The top level holds the state register, the next-state mux from the package function and the
//     found decode.
// TESTING
//   1 Default params. Apply rst mid-clock, release, then stream j=1,0,0,1,0 with en=1
//     -> found=1 only in the cycle after the 5th bit; count=1.
//   2 OVERLAP=1. Stream 1,0,0,1,0,0,1,0 -> found pulses after bit 5 and after bit 8; count=2.
//   3 OVERLAP=0, same stream -> a single pulse after bit 5; state=2 after bit 8; count=1.
//   4 Drop en for 3 cycles while in S5 -> found stays 1 and count unchanged. Also stream
//     1,0,0,0 -> state 1,2,3,0 (mismatch fallback).
//   5 CNT_W=2. Five overlapping matches -> count=3, sat=1. Then clr_cnt together with a match edge
//     -> count=0, sat=0, found=1.
//   6 rst pulse asynchronous to clk while in S4 -> state=0 and found=0 immediately. Next stream
//     1,0,0,1,0 detects normally.

Source files
------------

// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - elaboration-time helpers for the parametrised Moore sequence detector
`ifndef SEQ_DET_SW
`define SEQ_DET_SW(len) (seq_det_pkg::clog2((len) + 1))
`endif

package seq_det_pkg;

  localparam int MAX_LEN = 16;
  localparam int MAX_SW  = 5;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Longest proper prefix of the pattern that is also a suffix of it.
  function automatic int border(input logic [MAX_LEN-1:0] pattern, input int len);
    int p;
    int res;
    p   = {16'b0, pattern};
    res = 0;
    for (int b = len - 1; b >= 1; b--) begin
      if (res == 0 && (p >> (len - b)) == (p & ((1 << b) - 1))) res = b;
    end
    return res;
  endfunction

  // KMP transition: longest prefix that is a suffix of (prefix_k, b); k > len maps to S0.
  function automatic logic [MAX_SW-1:0] next_state(input logic [MAX_LEN-1:0] pattern,
                                                   input int len, input int k,
                                                   input logic b, input logic overlap);
    int p;
    int kk;
    int h;
    int res;
    p   = {16'b0, pattern};
    res = 0;
    kk  = 0;
    if (k <= len) begin
      if (k < len) kk = k;
      else if (overlap) kk = border(pattern, len);
      else kk = 0;
      h = ((p >> (len - kk)) << 1) | {31'b0, b};
      for (int m = kk + 1; m >= 1; m--) begin
        if (res == 0 && m <= len && (h & ((1 << m) - 1)) == (p >> (len - m))) res = m;
      end
    end
    return MAX_SW'(res);
  endfunction

endpackage

// File: rtl/seq_det_match_counter.sv
// rtl/seq_det_match_counter.sv - saturating match counter with synchronous clear
module seq_det_match_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  logic [CNT_W-1:0] r_count;

  assign count = r_count;
  assign sat   = &r_count;

  // Clear wins over a coincident increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && !sat) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/moore_seq_detector_param.sv
// rtl/moore_seq_detector_param.sv - Moore serial-pattern detector with KMP fallback table
module moore_seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                 PAT_LEN = 5,
  parameter logic [PAT_LEN-1:0] PATTERN = 5'b10010,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 8,
  localparam int                SW      = clog2(PAT_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             j,
  input  logic             clr_cnt,
  output logic             found,
  output logic [SW-1:0]    state,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam int            TBL  = 2 ** (SW + 1);
  localparam logic [SW-1:0] FULL = SW'(PAT_LEN);

  logic [SW-1:0] w_table [TBL];
  logic [SW-1:0] r_state;
  logic [SW-1:0] w_next;
  logic          w_inc;

  // Table indexed by {state, j}; unused encodings above PAT_LEN resolve to S0.
  for (genvar g = 0; g < TBL; g++) begin : g_tbl
    localparam logic [MAX_SW-1:0] NS =
      next_state(MAX_LEN'(PATTERN), PAT_LEN, g / 2, (g % 2) == 1, OVERLAP);
    assign w_table[g] = NS[SW-1:0];
  end

  always_comb begin
    w_next = w_table[{r_state, j}];
    w_inc  = en && (w_next == FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= '0;
    end else if (en) begin
      r_state <= w_next;
    end
  end

  assign state = r_state;
  assign found = (r_state == FULL);

  seq_det_match_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_inc),
    .clr   (clr_cnt),
    .count (count),
    .sat   (sat)
  );

endmodule

// File: tb/tb_moore_seq_detector_param.sv
// tb/tb_moore_seq_detector_param.sv - directed bench over overlap, non-overlap and 2-bit counter variants
module tb_moore_seq_detector_param;

  logic clk = 1'b0;
  logic rst, en, j, clr_cnt;

  logic       ov_found, nov_found, c2_found;
  logic [2:0] ov_state, nov_state, c2_state;
  logic [7:0] ov_count, nov_count;
  logic [1:0] c2_count;
  logic       ov_sat, nov_sat, c2_sat;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  moore_seq_detector_param u_ov (
    .clk(clk), .rst(rst), .en(en), .j(j), .clr_cnt(clr_cnt),
    .found(ov_found), .state(ov_state), .count(ov_count), .sat(ov_sat)
  );

  moore_seq_detector_param #(.OVERLAP(1'b0)) u_nov (
    .clk(clk), .rst(rst), .en(en), .j(j), .clr_cnt(clr_cnt),
    .found(nov_found), .state(nov_state), .count(nov_count), .sat(nov_sat)
  );

  moore_seq_detector_param #(.CNT_W(2)) u_c2 (
    .clk(clk), .rst(rst), .en(en), .j(j), .clr_cnt(clr_cnt),
    .found(c2_found), .state(c2_state), .count(c2_count), .sat(c2_sat)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ov(input string tag, input int st, input int fd, input int ct);
    chk({tag, ".ov.state"}, {29'b0, ov_state}, st);
    chk({tag, ".ov.found"}, {31'b0, ov_found}, fd);
    chk({tag, ".ov.count"}, {24'b0, ov_count}, ct);
  endtask

  task automatic chk_nov(input string tag, input int st, input int fd, input int ct);
    chk({tag, ".nov.state"}, {29'b0, nov_state}, st);
    chk({tag, ".nov.found"}, {31'b0, nov_found}, fd);
    chk({tag, ".nov.count"}, {24'b0, nov_count}, ct);
  endtask

  task automatic chk_c2(input string tag, input int st, input int fd, input int ct, input int s);
    chk({tag, ".c2.state"}, {29'b0, c2_state}, st);
    chk({tag, ".c2.found"}, {31'b0, c2_found}, fd);
    chk({tag, ".c2.count"}, {30'b0, c2_count}, ct);
    chk({tag, ".c2.sat"},   {31'b0, c2_sat}, s);
  endtask

  task automatic step(input logic jv, input logic clr);
    @(negedge clk);
    j = jv; en = 1'b1; clr_cnt = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic jv);
    @(negedge clk);
    j = jv; en = 1'b0; clr_cnt = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; j = 1'b0; clr_cnt = 1'b0;

    // 1: async reset mid-cycle, then one full match
    #12 rst = 1'b1;
    #1;
    chk_ov("t1.rst", 0, 0, 0);
    chk_nov("t1.rst", 0, 0, 0);
    chk_c2("t1.rst", 0, 0, 0, 0);
    chk("t1.rst.ov.sat", {31'b0, ov_sat}, 0);
    @(negedge clk) rst = 1'b0;
    step(1'b1, 1'b0); chk_ov("t1.b1", 1, 0, 0);
    step(1'b0, 1'b0); chk_ov("t1.b2", 2, 0, 0);
    step(1'b0, 1'b0); chk_ov("t1.b3", 3, 0, 0);
    step(1'b1, 1'b0); chk_ov("t1.b4", 4, 0, 0);
    step(1'b0, 1'b0);
    chk_ov("t1.b5", 5, 1, 1);
    chk_nov("t1.b5", 5, 1, 1);
    chk_c2("t1.b5", 5, 1, 1, 0);

    // 2/3: continue with 0,1,0 -> overlapping match vs restart
    step(1'b0, 1'b0);
    chk_ov("t2.b6", 3, 0, 1);
    chk_nov("t3.b6", 0, 0, 1);
    step(1'b1, 1'b0);
    chk_ov("t2.b7", 4, 0, 1);
    chk_nov("t3.b7", 1, 0, 1);
    step(1'b0, 1'b0);
    chk_ov("t2.b8", 5, 1, 2);
    chk_nov("t3.b8", 2, 0, 1);
    chk_c2("t2.b8", 5, 1, 2, 0);

    // 4: hold with en low, then mismatch fallback 1,0,0,0
    idle(1'b1); idle(1'b0); idle(1'b1);
    chk_ov("t4.hold", 5, 1, 2);
    chk_nov("t4.hold", 2, 0, 1);
    step(1'b1, 1'b0); chk_ov("t4.m1", 1, 0, 2);
    step(1'b0, 1'b0); chk_ov("t4.m2", 2, 0, 2);
    step(1'b0, 1'b0); chk_ov("t4.m3", 3, 0, 2);
    step(1'b0, 1'b0);
    chk_ov("t4.m4", 0, 0, 2);
    chk_nov("t4.m4", 0, 0, 1);

    // 5: saturation of the 2-bit counter, then clear on a match edge
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
    chk_ov("t5.m3", 5, 1, 3);
    chk_nov("t5.m3", 5, 1, 2);
    chk_c2("t5.m3", 5, 1, 3, 1);
    step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
    chk_ov("t5.m4", 5, 1, 4);
    chk_nov("t5.m4", 2, 0, 2);
    chk_c2("t5.m4", 5, 1, 3, 1);
    step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b1);
    chk_ov("t5.clr", 5, 1, 0);
    chk_nov("t5.clr", 5, 1, 0);
    chk_c2("t5.clr", 5, 1, 0, 0);

    // 6: async reset while in S4, then normal detection
    step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    chk_ov("t6.flush", 0, 0, 0);
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0);
    chk_ov("t6.s4", 4, 0, 0);
    chk_nov("t6.s4", 4, 0, 0);
    #2 rst = 1'b1; en = 1'b0;
    #1;
    chk_ov("t6.rst", 0, 0, 0);
    chk_nov("t6.rst", 0, 0, 0);
    chk_c2("t6.rst", 0, 0, 0, 0);
    @(negedge clk) rst = 1'b0;
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0);
    chk_ov("t6.r4", 4, 0, 0);
    step(1'b0, 1'b0);
    chk_ov("t6.r5", 5, 1, 1);
    chk_nov("t6.r5", 5, 1, 1);
    chk_c2("t6.r5", 5, 1, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
